// File: rtl/sdram_memtest.sv
`timescale 1ns/1ps
// Built-in SDRAM test sequencer: writes {8'hA5, addr} over a window, reads it back and
// compares, then repeats with the inverted pattern. Controller strobes come from CLOCK_50.
module sdram_memtest #(
  parameter logic [23:0] START_ADDR = 24'h000000,
  parameter logic [23:0] END_ADDR   = 24'h0003FF,
  parameter int          TIMEOUT    = 1023
) (
  input  logic        CLOCK_100_del_3ns,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        fail,
  output logic        timeout_err,
  output logic [15:0] error_count,
  output logic [23:0] first_err_addr,
  output logic [31:0] first_err_data,
  output logic [23:0] address,
  output logic [31:0] data_in,
  output logic        req_write,
  output logic        req_read,
  input  logic [31:0] data_out,
  input  logic        data_valid,
  input  logic        write_complete
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, CHECK, DONE} state_t;

  localparam int             CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [23:0]   addr_q, addr_d;
  logic          pass_q, pass_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   rd_data_q, rd_data_d;
  logic [15:0]   err_q, err_d;
  logic [23:0]   fa_q, fa_d;
  logic [31:0]   fd_q, fd_d;
  logic          tout_q, tout_d;
  logic [31:0]   data_in_q;
  logic [2:0]    wc_sync, dv_sync;
  logic          wc_rise, dv_rise;
  logic          last_addr;

  function automatic logic [31:0] pattern(input logic [23:0] a, input logic p);
    pattern = p ? ~{8'hA5, a} : {8'hA5, a};
  endfunction

  // Two flops resynchronise each strobe; the third flop turns it into a one-cycle
  // rising-edge pulse so a strobe held over several fast cycles counts once.
  always_ff @(posedge CLOCK_100_del_3ns) begin
    if (rst) begin
      wc_sync <= '0;
      dv_sync <= '0;
      wc_rise <= 1'b0;
      dv_rise <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample pre-edge values, so the
      // shift chain order and the edge detect below do not depend on statement order.
      wc_sync <= {wc_sync[1:0], write_complete};
      dv_sync <= {dv_sync[1:0], data_valid};
      wc_rise <= wc_sync[1] & ~wc_sync[2];
      dv_rise <= dv_sync[1] & ~dv_sync[2];
    end
  end

  assign last_addr = (addr_q == END_ADDR);

  always_comb begin
    // NOTE: every variable gets a default before the case, so no path leaves one
    // unassigned and no latch is inferred.
    state_d   = state_q;
    addr_d    = addr_q;
    pass_d    = pass_q;
    cnt_d     = cnt_q;
    rd_data_d = rd_data_q;
    err_d     = err_q;
    fa_d      = fa_q;
    fd_d      = fd_q;
    tout_d    = tout_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          err_d   = '0;
          fa_d    = '0;
          fd_d    = '0;
          tout_d  = 1'b0;
          pass_d  = 1'b0;
          addr_d  = START_ADDR;
          state_d = WR_REQ;
        end
      end
      WR_REQ: begin
        cnt_d   = '0;
        state_d = WR_WAIT;
      end
      WR_WAIT: begin
        if (wc_rise) begin
          addr_d  = last_addr ? START_ADDR : addr_q + 24'd1;
          state_d = last_addr ? RD_REQ : WR_REQ;
        end else if (cnt_q == CNT_LAST) begin
          tout_d  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RD_REQ: begin
        cnt_d   = '0;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (dv_rise) begin
          rd_data_d = data_out;
          state_d   = CHECK;
        end else if (cnt_q == CNT_LAST) begin
          tout_d  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CHECK: begin
        if (rd_data_q != pattern(addr_q, pass_q)) begin
          if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
          if (err_q == 16'd0) begin
            fa_d = addr_q;
            fd_d = rd_data_q;
          end
        end
        if (last_addr && pass_q) begin
          state_d = DONE;
        end else if (last_addr) begin
          pass_d  = 1'b1;
          addr_d  = START_ADDR;
          state_d = WR_REQ;
        end else begin
          addr_d  = addr_q + 24'd1;
          state_d = RD_REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_100_del_3ns) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      pass_q    <= 1'b0;
      cnt_q     <= '0;
      rd_data_q <= '0;
      err_q     <= '0;
      fa_q      <= '0;
      fd_q      <= '0;
      tout_q    <= 1'b0;
      data_in_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      pass_q    <= pass_d;
      cnt_q     <= cnt_d;
      rd_data_q <= rd_data_d;
      err_q     <= err_d;
      fa_q      <= fa_d;
      fd_q      <= fd_d;
      tout_q    <= tout_d;
      // Write data only moves when a new request is set up, so it stays stable
      // through the whole WAIT state that follows.
      if (state_d == WR_REQ || state_d == RD_REQ) data_in_q <= pattern(addr_d, pass_d);
    end
  end

  assign busy           = (state_q != IDLE) && (state_q != DONE);
  assign done           = (state_q == DONE);
  assign fail           = done && ((err_q != 16'd0) || tout_q);
  assign timeout_err    = tout_q;
  assign error_count    = err_q;
  assign first_err_addr = fa_q;
  assign first_err_data = fd_q;
  assign address        = addr_q;
  assign data_in        = data_in_q;
  assign req_write      = (state_q == WR_REQ);
  assign req_read       = (state_q == RD_REQ);

endmodule

// File: tb/tb_sdram_memtest.sv
`timescale 1ns/1ps
// Scoreboard bench for sdram_memtest: two instances (4-word window, single word at
// 24'hFFFFFF), each with a behavioural CLOCK_50 controller model and a request monitor.
module tb_sdram_memtest;

  localparam int TO = 40;

  typedef struct packed {
    logic        fail;
    logic        tout;
    logic [15:0] cnt;
    logic [23:0] fa;
    logic [31:0] fd;
  } res_t;
  typedef logic [55:0] wr_q_t [$];
  typedef logic [23:0] rd_q_t [$];
  typedef res_t        res_q_t [$];

  logic clk   = 1'b0;
  logic clk50 = 1'b0;
  logic rst   = 1'b1;
  always #5  clk   = ~clk;
  always #10 clk50 = ~clk50;

  logic        start_v [2];
  logic        drop_v [2];
  logic        corrupt_v [2];
  logic        busy_v [2], done_v [2], fail_v [2], tout_v [2], rw_v [2], rr_v [2];
  logic [15:0] ecnt_v [2];
  logic [23:0] fa_v [2], addr_v [2];
  logic [31:0] fd_v [2], din_v [2];

  wr_q_t  exp_wr [2];
  rd_q_t  exp_rd [2];
  res_q_t exp_res [2];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, want);
  endtask

  function automatic res_t mk_res(input logic f, input logic t, input logic [15:0] c,
                                  input logic [23:0] a, input logic [31:0] d);
    mk_res = '{fail: f, tout: t, cnt: c, fa: a, fd: d};
  endfunction

  function automatic logic [159:0] outs(input int g);
    outs = 160'({busy_v[g], done_v[g], fail_v[g], tout_v[g], ecnt_v[g], fa_v[g], fd_v[g],
                 addr_v[g], din_v[g], rw_v[g], rr_v[g]});
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_ch
    logic        wc, dv;
    logic [31:0] dout;
    logic [23:0] wq [$];
    logic [31:0] wdq [$];
    logic [23:0] rq [$];
    logic [31:0] mem [logic [23:0]];
    logic [23:0] ma;
    logic [31:0] md;
    logic [55:0] ew;
    logic [23:0] er;
    res_t        eres;
    int          n_wr, n_rd, cyc, last_wr_cyc, done_cyc;
    logic        done_q;

    sdram_memtest #(
      .START_ADDR(g == 1 ? 24'hFFFFFF : 24'h000000),
      .END_ADDR  (g == 1 ? 24'hFFFFFF : 24'h000003),
      .TIMEOUT   (TO)
    ) dut (
      .CLOCK_100_del_3ns(clk),
      .rst           (rst),
      .start         (start_v[g]),
      .busy          (busy_v[g]),
      .done          (done_v[g]),
      .fail          (fail_v[g]),
      .timeout_err   (tout_v[g]),
      .error_count   (ecnt_v[g]),
      .first_err_addr(fa_v[g]),
      .first_err_data(fd_v[g]),
      .address       (addr_v[g]),
      .data_in       (din_v[g]),
      .req_write     (rw_v[g]),
      .req_read      (rr_v[g]),
      .data_out      (dout),
      .data_valid    (dv),
      .write_complete(wc)
    );

    // Controller front end: latch one-cycle requests into a pending queue.
    always @(negedge clk) begin
      if (rw_v[g]) begin
        wq.push_back(addr_v[g]);
        wdq.push_back(din_v[g]);
      end
      if (rr_v[g]) rq.push_back(addr_v[g]);
    end

    // Controller back end in the CLOCK_50 domain.
    initial begin
      wc = 1'b0; dv = 1'b0; dout = '0;
      forever begin
        @(posedge clk50);
        if (wq.size() != 0) begin
          ma = wq.pop_front();
          md = wdq.pop_front();
          repeat (2) @(posedge clk50);
          mem[ma] = md;
          if (!drop_v[g]) begin
            wc = 1'b1;
            @(posedge clk50);
            wc = 1'b0;
          end
        end else if (rq.size() != 0) begin
          ma = rq.pop_front();
          repeat (2) @(posedge clk50);
          dout = mem.exists(ma) ? mem[ma] : 32'h0;
          if (corrupt_v[g] && ma == 24'h000001 && dout == 32'hA5000001) dout = 32'h0;
          dv = 1'b1;
          @(posedge clk50);
          dv = 1'b0;
        end
      end
    end

    // Monitor: compare every request and every completed run against the queues.
    initial begin
      n_wr = 0; n_rd = 0; cyc = 0; last_wr_cyc = 0; done_cyc = 0; done_q = 1'b0;
      forever begin
        @(negedge clk);
        cyc++;
        if (rw_v[g]) begin
          n_wr++;
          last_wr_cyc = cyc;
          check($sformatf("wr_expected_%0d", g), 160'(exp_wr[g].size() != 0), 160'(1));
          if (exp_wr[g].size() != 0) begin
            ew = exp_wr[g].pop_front();
            check($sformatf("wr_addr_data_%0d", g), 160'({addr_v[g], din_v[g]}), 160'(ew));
          end
        end
        if (rr_v[g]) begin
          n_rd++;
          check($sformatf("rd_expected_%0d", g), 160'(exp_rd[g].size() != 0), 160'(1));
          if (exp_rd[g].size() != 0) begin
            er = exp_rd[g].pop_front();
            check($sformatf("rd_addr_%0d", g), 160'(addr_v[g]), 160'(er));
          end
        end
        if (done_v[g] && !done_q) begin
          done_cyc = cyc;
          check($sformatf("res_expected_%0d", g), 160'(exp_res[g].size() != 0), 160'(1));
          if (exp_res[g].size() != 0) begin
            eres = exp_res[g].pop_front();
            check($sformatf("result_%0d", g),
                  160'({fail_v[g], tout_v[g], ecnt_v[g], fa_v[g], fd_v[g]}), 160'(eres));
          end
        end
        done_q = done_v[g];
      end
    end
  end

  task automatic push_run(input int g, input int lo, input int hi, input res_t r);
    for (int p = 0; p < 2; p++) begin
      for (int a = lo; a <= hi; a++)
        exp_wr[g].push_back({24'(a), (p == 1) ? ~{8'hA5, 24'(a)} : {8'hA5, 24'(a)}});
      for (int a = lo; a <= hi; a++) exp_rd[g].push_back(24'(a));
    end
    exp_res[g].push_back(r);
  endtask

  task automatic pulse_start(input int g);
    @(negedge clk) start_v[g] = 1'b1;
    @(negedge clk) start_v[g] = 1'b0;
    check($sformatf("busy_after_start_%0d", g), 160'(busy_v[g]), 160'(1));
    check($sformatf("req_write_after_start_%0d", g), 160'(rw_v[g]), 160'(1));
  endtask

  task automatic wait_done(input int g, input int budget);
    int k = 0;
    while (!done_v[g] && k < budget) begin
      @(negedge clk);
      k++;
    end
    check($sformatf("done_reached_%0d", g), 160'(done_v[g]), 160'(1));
    @(negedge clk);
  endtask

  initial begin
    #300us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int b_wr, b_rd, k;
    for (int g = 0; g < 2; g++) begin
      start_v[g] = 1'b0; drop_v[g] = 1'b0; corrupt_v[g] = 1'b0;
    end
    repeat (3) @(negedge clk);
    check("reset_outputs_0", outs(0), 160'(0));
    check("reset_outputs_1", outs(1), 160'(0));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Clean run over 0x000..0x003.
    push_run(0, 0, 3, mk_res(1'b0, 1'b0, 16'd0, 24'd0, 32'd0));
    b_wr = g_ch[0].n_wr; b_rd = g_ch[0].n_rd;
    pulse_start(0);
    wait_done(0, 3000);
    check("clean_write_count", 160'(g_ch[0].n_wr - b_wr), 160'(8));
    check("clean_read_count", 160'(g_ch[0].n_rd - b_rd), 160'(8));
    check("clean_fail", 160'(fail_v[0]), 160'(0));

    // Read of 0x001 in pass 0 comes back as zero.
    corrupt_v[0] = 1'b1;
    push_run(0, 0, 3, mk_res(1'b1, 1'b0, 16'd1, 24'h000001, 32'h0));
    pulse_start(0);
    wait_done(0, 3000);
    corrupt_v[0] = 1'b0;
    check("corrupt_error_count", 160'(ecnt_v[0]), 160'(1));
    check("corrupt_first_addr", 160'(fa_v[0]), 160'(24'h000001));
    check("corrupt_fail", 160'(fail_v[0]), 160'(1));

    // write_complete never arrives.
    drop_v[0] = 1'b1;
    exp_wr[0].push_back({24'h000000, 32'hA5000000});
    exp_res[0].push_back(mk_res(1'b1, 1'b1, 16'd0, 24'd0, 32'd0));
    b_wr = g_ch[0].n_wr; b_rd = g_ch[0].n_rd;
    pulse_start(0);
    wait_done(0, 500);
    check("timeout_latency", 160'(g_ch[0].done_cyc - g_ch[0].last_wr_cyc), 160'(TO + 1));
    check("timeout_no_reads", 160'(g_ch[0].n_rd - b_rd), 160'(0));
    check("timeout_one_write", 160'(g_ch[0].n_wr - b_wr), 160'(1));
    check("timeout_err", 160'(tout_v[0]), 160'(1));
    repeat (10) @(negedge clk);
    drop_v[0] = 1'b0;

    // start pulsed again while busy.
    push_run(0, 0, 3, mk_res(1'b0, 1'b0, 16'd0, 24'd0, 32'd0));
    b_wr = g_ch[0].n_wr; b_rd = g_ch[0].n_rd;
    pulse_start(0);
    repeat (30) @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk) start_v[0] = 1'b0;
    check("busy_mid_start", 160'(busy_v[0]), 160'(1));
    wait_done(0, 3000);
    check("mid_start_req_count", 160'((g_ch[0].n_wr - b_wr) + (g_ch[0].n_rd - b_rd)), 160'(16));

    // rst while in RD_WAIT, then a fresh run.
    push_run(0, 0, 3, mk_res(1'b0, 1'b0, 16'd0, 24'd0, 32'd0));
    pulse_start(0);
    k = 0;
    while (!rr_v[0] && k < 1000) begin
      @(negedge clk);
      k++;
    end
    check("rd_req_seen", 160'(rr_v[0]), 160'(1));
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    check("reset_in_rd_wait", outs(0), 160'(0));
    rst = 1'b0;
    exp_wr[0].delete(); exp_rd[0].delete(); exp_res[0].delete();
    repeat (40) @(negedge clk);
    check("stale_dv_ignored", 160'({busy_v[0], done_v[0], ecnt_v[0]}), 160'(0));
    push_run(0, 0, 3, mk_res(1'b0, 1'b0, 16'd0, 24'd0, 32'd0));
    b_wr = g_ch[0].n_wr; b_rd = g_ch[0].n_rd;
    pulse_start(0);
    wait_done(0, 3000);
    check("post_reset_req_count", 160'((g_ch[0].n_wr - b_wr) + (g_ch[0].n_rd - b_rd)), 160'(16));
    check("post_reset_fail", 160'(fail_v[0]), 160'(0));

    // Single-word window at the top of the address space.
    push_run(1, 24'hFFFFFF, 24'hFFFFFF, mk_res(1'b0, 1'b0, 16'd0, 24'd0, 32'd0));
    b_wr = g_ch[1].n_wr; b_rd = g_ch[1].n_rd;
    pulse_start(1);
    wait_done(1, 1000);
    check("top_write_count", 160'(g_ch[1].n_wr - b_wr), 160'(2));
    check("top_read_count", 160'(g_ch[1].n_rd - b_rd), 160'(2));
    check("top_addr_held", 160'(addr_v[1]), 160'(24'hFFFFFF));
    check("top_fail", 160'(fail_v[1]), 160'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
